// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver. Two-flop input synchronizer, mid-bit
//                sampling driven by a bit-period counter, one-cycle pulses
//                for a good byte (rx_valid) or a bad stop bit (frame_err),
//                and a BREAK state that waits out a line held low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // The start bit is checked half a period in so every later sample lands mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data_nxt;
  logic             valid_nxt, err_nxt;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, counter, shift and output-pulse decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    rx_data_nxt = rx_data;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = 3'd0;
          // A line that is back high by mid-start was only a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            rx_data_nxt = shreg;
            valid_nxt   = 1'b1;
            state_nxt   = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait for the line to go idle so a held-low line yields nothing more.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

  // Busy whenever a frame (or a break) is in progress.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule
`default_nettype wire
